// File: rtl/alu_exec_pkg.sv
// Shared ALU definitions: op-code localparams used by both the ALU control decoder and alu_exec,
// plus the shift-kind encoding consumed by the iterative shifter.
package alu_exec_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SRL = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRA = 4'b0101;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_AND = 4'b0111;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_e;

    // Maps a shift op code to the shifter's direction/fill selection.
    function automatic shift_kind_e shift_kind(input logic [OP_W-1:0] op);
        case (op)
            ALU_SRL: shift_kind = SH_SRL;
            ALU_SRA: shift_kind = SH_SRA;
            default: shift_kind = SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_shift_unit.sv
// Iterative 1-bit-per-cycle shifter: owns accumulator, remaining-step counter and fill bit.
module alu_shift_unit
    import alu_exec_pkg::*;
#(
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  shift_kind_e         kind_in,
    input  logic [XLEN-1:0]     value,
    input  logic [SHAMT_W-1:0]  amount,
    output logic [XLEN-1:0]     first_c,
    output logic [XLEN-1:0]     next_c,
    output logic                last_c
);

    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] count;
    logic               fill;
    shift_kind_e        kind;
    logic               fill_in;

    // SRA fill comes from the original operand's sign bit and is frozen at load.
    assign fill_in = (kind_in == SH_SRA) ? value[XLEN-1] : 1'b0;

    assign first_c = (kind_in == SH_SLL) ? {value[XLEN-2:0], 1'b0} : {fill_in, value[XLEN-1:1]};
    assign next_c  = (kind == SH_SLL)    ? {acc[XLEN-2:0], 1'b0}   : {fill, acc[XLEN-1:1]};
    assign last_c  = (count == SHAMT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            fill  <= 1'b0;
            kind  <= SH_SLL;
        end else if (load) begin
            acc   <= first_c;
            count <= amount - SHAMT_W'(1);
            fill  <= fill_in;
            kind  <= kind_in;
        end else if (step) begin
            acc   <= next_c;
            count <= count - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/sub, iterative shifts with start/done handshake.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  ALUctrl_lines,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e             state, state_next;
    logic [XLEN-1:0]    result_next;
    logic               done_next;
    logic               load, step;
    logic [SHAMT_W-1:0] amount;
    logic [XLEN-1:0]    first_c, next_c;
    logic               last_c;

    assign amount = op_b[SHAMT_W-1:0];
    assign busy   = (state == ST_SHIFT);
    assign zero   = (result == '0);

    alu_shift_unit #(.XLEN(XLEN)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .kind_in (shift_kind(ALUctrl_lines)),
        .value   (op_a),
        .amount  (amount),
        .first_c (first_c),
        .next_c  (next_c),
        .last_c  (last_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            result <= result_next;
            done   <= done_next;
        end
    end

    // Next-state and datapath; start is only looked at in IDLE, so requests while busy drop.
    always_comb begin
        state_next  = state;
        result_next = result;
        done_next   = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    done_next = 1'b1;
                    case (ALUctrl_lines)
                        ALU_ADD: result_next = op_a + op_b;
                        ALU_SUB: result_next = op_a - op_b;
                        ALU_XOR: result_next = op_a ^ op_b;
                        ALU_OR:  result_next = op_a | op_b;
                        ALU_AND: result_next = op_a & op_b;
                        ALU_SLL, ALU_SRL, ALU_SRA: begin
                            if (amount == '0) begin
                                result_next = op_a;
                            end else if (amount == SHAMT_W'(1)) begin
                                result_next = first_c;
                            end else begin
                                done_next  = 1'b0;
                                load       = 1'b1;
                                state_next = ST_SHIFT;
                            end
                        end
                        default: result_next = '0;
                    endcase
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (last_c) begin
                    result_next = next_c;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
